// File: rtl/data_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_bus_bridge_pkg
//  Description : Shared types and constants for the data bus bridge: MMIO
//                word offsets, UART status bit positions, target-select enum,
//                bus-error read pattern and a byte-enable merge helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_bus_bridge_pkg;

    // MMIO word offsets, i.e. addr[7:3] of the 256-byte window
    localparam logic [4:0] OFF_MTIME     = 5'h00;
    localparam logic [4:0] OFF_MTIMECMP  = 5'h01;
    localparam logic [4:0] OFF_LED       = 5'h02;
    localparam logic [4:0] OFF_UART_TX   = 5'h03;
    localparam logic [4:0] OFF_UART_STAT = 5'h04;

    // UART_STATUS bit positions
    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_BUSERR = 3;

    localparam logic [63:0] BUSERR_PATTERN = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_MMIO = 2'd2
    } sel_e;

    // Written bytes take the new data, unwritten bytes keep the old value
    function automatic logic [63:0] byte_merge(input logic [63:0] cur,
                                               input logic [63:0] wr,
                                               input logic [7:0]  be);
        logic [63:0] res;
        for (int i = 0; i < 8; i++) begin
            res[i*8 +: 8] = be[i] ? wr[i*8 +: 8] : cur[i*8 +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_bus_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_bus_bridge_if
//  Description : Core data-access bus (data_sram_* side of the core).
//                master: the core (drives request, receives read data)
//                slave : the bridge (receives request, returns read data)
//  Signals     : cpu_en, cpu_we[7:0], cpu_addr[63:0], cpu_wdata[63:0],
//                cpu_rdata[63:0] (valid one cycle after the request)
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_bus_bridge_if;
    logic        cpu_en;
    logic [7:0]  cpu_we;
    logic [63:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic [63:0] cpu_rdata;

    modport master (output cpu_en, cpu_we, cpu_addr, cpu_wdata,
                    input  cpu_rdata);
    modport slave  (input  cpu_en, cpu_we, cpu_addr, cpu_wdata,
                    output cpu_rdata);
endinterface
`default_nettype wire

// File: rtl/data_bus_bridge_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Parameterised synchronous FIFO. Pushes while full and pops
//                while empty are ignored; full/empty reflect the registered
//                count, so a same-cycle pop never makes room for a push.
//  Ports       : clk, rst (sync, active-high), push, pop, din[WIDTH-1:0],
//                dout[WIDTH-1:0] (head), full, empty
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 4,     // power of two, >= 2
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop  & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);   // wraps at DEPTH
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/data_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : data_bus_bridge
//  Description : Decodes core data accesses to data RAM, an MMIO block
//                (64-bit mtime/mtimecmp timer driving ext_int, LED register,
//                UART TX FIFO) or unmapped space. Keeps the 1-cycle read
//                latency of the SRAM port; never stalls.
//  Ports       : clk, rst (sync, active-high), cpu (data_bus_bridge_if.slave),
//                ram_en/ram_we/ram_addr/ram_wdata out, ram_rdata in,
//                ext_int, led[15:0], uart_tx_valid, uart_tx_data[7:0],
//                uart_tx_ready in
//  Options     : DATA_BUS_BRIDGE_BUSERR_EN - sticky bus-error flag (status
//                bit3) and DEAD_BEEF read pattern for unmapped/reserved reads
//  Revision    : 1.0 - initial release
// ============================================================================
module data_bus_bridge
    import data_bus_bridge_pkg::*;
#(
    parameter logic [63:0] RAM_BASE        = 64'h0000_0000_8000_0000,
    parameter int          RAM_SIZE_LOG2   = 20,
    parameter logic [63:0] MMIO_BASE       = 64'h0000_0000_1000_0000,
    parameter int          TIMER_DIV       = 1,
    parameter int          UART_FIFO_DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    data_bus_bridge_if.slave   cpu,
    output logic               ram_en,
    output logic [7:0]         ram_we,
    output logic [63:0]        ram_addr,
    output logic [63:0]        ram_wdata,
    input  wire logic [63:0]   ram_rdata,
    output logic               ext_int,
    output logic [15:0]        led,
    output logic               uart_tx_valid,
    output logic [7:0]         uart_tx_data,
    input  wire logic          uart_tx_ready
);
    localparam int             PW        = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TIMER_DIV - 1);

    // ---------------- decode ----------------
    logic       ram_hit, mmio_hit, is_read, mmio_wr, reserved, push_req;
    logic [4:0] off;
    sel_e       sel_req;

    assign ram_hit  = (cpu.cpu_addr >> RAM_SIZE_LOG2) == (RAM_BASE >> RAM_SIZE_LOG2);
    assign mmio_hit = ~ram_hit & (cpu.cpu_addr[63:8] == MMIO_BASE[63:8]);
    assign off      = cpu.cpu_addr[7:3];
    assign is_read  = cpu.cpu_en & ~(|cpu.cpu_we);
    assign mmio_wr  = cpu.cpu_en & (|cpu.cpu_we) & mmio_hit;
    assign reserved = mmio_hit & (off > OFF_UART_STAT);
    assign push_req = mmio_wr & (off == OFF_UART_TX) & cpu.cpu_we[0];
    assign sel_req  = ram_hit ? SEL_RAM : (mmio_hit ? SEL_MMIO : SEL_NONE);

    assign ram_en    = cpu.cpu_en & ram_hit;
    assign ram_we    = cpu.cpu_we;
    assign ram_addr  = cpu.cpu_addr;
    assign ram_wdata = cpu.cpu_wdata;

    // ---------------- state ----------------
    logic [63:0]   mtime_q,      mtime_d;
    logic [63:0]   mtimecmp_q,   mtimecmp_d;
    logic [PW-1:0] presc_q,      presc_d;
    logic          ext_int_q,    ext_int_d;
    logic [15:0]   led_q,        led_d;
    logic          ovf_q,        ovf_d;
    sel_e          sel_q,        sel_d;
    logic [63:0]   mmio_rdata_q, mmio_rdata_d;
    logic          fifo_full, fifo_empty;
    logic          buserr_bit;

`ifdef DATA_BUS_BRIDGE_BUSERR_EN
    logic buserr_q, buserr_d;
    assign buserr_bit = buserr_q;
`else
    assign buserr_bit = 1'b0;
`endif

    uart_tx_fifo #(
        .DEPTH (UART_FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (uart_tx_ready),
        .din   (cpu.cpu_wdata[7:0]),
        .dout  (uart_tx_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign uart_tx_valid = ~fifo_empty;
    assign ext_int       = ext_int_q;
    assign led           = led_q;
    assign cpu.cpu_rdata = (sel_q == SEL_RAM) ? ram_rdata : mmio_rdata_q;

    always_comb begin
        mtime_d      = mtime_q;
        mtimecmp_d   = mtimecmp_q;
        presc_d      = presc_q;
        led_d        = led_q;
        ovf_d        = ovf_q;
        ext_int_d    = (mtime_q >= mtimecmp_q);
        sel_d        = cpu.cpu_en ? sel_req : SEL_NONE;
        mmio_rdata_d = '0;
`ifdef DATA_BUS_BRIDGE_BUSERR_EN
        buserr_d     = buserr_q;
`endif

        // prescaler keeps running; a same-cycle MTIME write overrides the tick
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            mtime_d = mtime_q + 64'd1;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (mmio_wr) begin
            case (off)
                OFF_MTIME:    mtime_d    = byte_merge(mtime_q, cpu.cpu_wdata, cpu.cpu_we);
                OFF_MTIMECMP: mtimecmp_d = byte_merge(mtimecmp_q, cpu.cpu_wdata, cpu.cpu_we);
                OFF_LED: begin
                    if (cpu.cpu_we[0]) led_d[7:0]  = cpu.cpu_wdata[7:0];
                    if (cpu.cpu_we[1]) led_d[15:8] = cpu.cpu_wdata[15:8];
                end
                OFF_UART_STAT: begin
                    if (cpu.cpu_we[0] && cpu.cpu_wdata[ST_OVF]) ovf_d = 1'b0;
`ifdef DATA_BUS_BRIDGE_BUSERR_EN
                    if (cpu.cpu_we[0] && cpu.cpu_wdata[ST_BUSERR]) buserr_d = 1'b0;
`endif
                end
                default: ;
            endcase
        end

        // full is the pre-pop state, matching the FIFO's own push gating
        if (push_req && fifo_full) ovf_d = 1'b1;

        if (is_read && mmio_hit) begin
            case (off)
                OFF_MTIME:     mmio_rdata_d = mtime_q;
                OFF_MTIMECMP:  mmio_rdata_d = mtimecmp_q;
                OFF_LED:       mmio_rdata_d = {48'd0, led_q};
                OFF_UART_STAT: mmio_rdata_d = {60'd0, buserr_bit, ovf_q, fifo_empty, fifo_full};
                default:       mmio_rdata_d = '0;
            endcase
        end

`ifdef DATA_BUS_BRIDGE_BUSERR_EN
        if (cpu.cpu_en && (sel_req == SEL_NONE || reserved)) begin
            buserr_d = 1'b1;
            if (is_read) mmio_rdata_d = BUSERR_PATTERN;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q      <= '0;
            mtimecmp_q   <= '1;
            presc_q      <= '0;
            ext_int_q    <= 1'b0;
            led_q        <= '0;
            ovf_q        <= 1'b0;
            sel_q        <= SEL_NONE;
            mmio_rdata_q <= '0;
`ifdef DATA_BUS_BRIDGE_BUSERR_EN
            buserr_q     <= 1'b0;
`endif
        end else begin
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            presc_q      <= presc_d;
            ext_int_q    <= ext_int_d;
            led_q        <= led_d;
            ovf_q        <= ovf_d;
            sel_q        <= sel_d;
            mmio_rdata_q <= mmio_rdata_d;
`ifdef DATA_BUS_BRIDGE_BUSERR_EN
            buserr_q     <= buserr_d;
`endif
        end
    end

    // reserved only matters for the bus-error option
    logic unused_reserved;
    assign unused_reserved = reserved;
endmodule
`default_nettype wire

// File: tb/tb_data_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_bus_bridge
//  Description : Self-checking bench for data_bus_bridge. Read expectations
//                and UART bytes are queued when driven and compared when the
//                bridge produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_bus_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        ram_en;
    logic [7:0]  ram_we;
    logic [63:0] ram_addr, ram_wdata, ram_rdata;
    logic        ext_int;
    logic [15:0] led;
    logic        uart_tx_valid, uart_tx_ready;
    logic [7:0]  uart_tx_data;

    int errors = 0;
    int checks = 0;
    logic [63:0] rd_q[$];
    logic [7:0]  uart_q[$];
    logic        exp_ovf;

    localparam logic [63:0] A_MTIME = 64'h1000_0000;
    localparam logic [63:0] A_CMP   = 64'h1000_0008;
    localparam logic [63:0] A_LED   = 64'h1000_0010;
    localparam logic [63:0] A_TX    = 64'h1000_0018;
    localparam logic [63:0] A_STAT  = 64'h1000_0020;
    localparam logic [63:0] JUNK    = 64'h5A5A_5A5A_5A5A_5A5A;
`ifdef DATA_BUS_BRIDGE_BUSERR_EN
    localparam logic [63:0] EXP_UNM = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [63:0] EXP_BE  = 64'h8;
`else
    localparam logic [63:0] EXP_UNM = 64'h0;
    localparam logic [63:0] EXP_BE  = 64'h0;
`endif

    always #5 clk = ~clk;

    data_bus_bridge_if bus();

    data_bus_bridge dut (
        .clk           (clk),
        .rst           (rst),
        .cpu           (bus),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .ext_int       (ext_int),
        .led           (led),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_ready (uart_tx_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] we, input logic [63:0] addr, input logic [63:0] wdata);
        bus.cpu_en = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        tick();
        bus.cpu_en = 1'b0; bus.cpu_we = 8'h00;
    endtask

    // ram_next is what the RAM returns in the response cycle
    task automatic bus_read(input string name, input logic [63:0] addr, input logic [63:0] exp,
                            input logic exp_ram_en, input logic [63:0] ram_next);
        logic [63:0] e;
        rd_q.push_back(exp);
        bus.cpu_en = 1'b1; bus.cpu_we = 8'h00; bus.cpu_addr = addr;
        #1;
        checks++;
        if (ram_en !== exp_ram_en) begin
            errors++;
            $display("FAIL %s ram_en: got %b want %b", name, ram_en, exp_ram_en);
        end
        tick();
        bus.cpu_en = 1'b0;
        ram_rdata  = ram_next;
        #1;
        e = rd_q.pop_front();
        checks++;
        if (bus.cpu_rdata !== e) begin
            errors++;
            $display("FAIL %s rdata: got %h want %h", name, bus.cpu_rdata, e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cpu_en = 1'b0; bus.cpu_we = 8'h00; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        ram_rdata = JUNK; uart_tx_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({bus.cpu_rdata, ext_int, led, uart_tx_valid, ram_en} !== {64'h0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: rdata=%h ext_int=%b led=%h valid=%b ram_en=%b want all 0",
                     bus.cpu_rdata, ext_int, led, uart_tx_valid, ram_en);
        end
        rst = 1'b0;
        bus_read("reset_mtimecmp", A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, JUNK);
        bus_read("reset_status", A_STAT, 64'h2, 1'b0, JUNK);
    endtask

    task automatic test_ram();
        bus_read("ram_read", 64'h8000_0010, 64'h1122_3344_5566_7788, 1'b1, 64'h1122_3344_5566_7788);
        bus.cpu_en = 1'b1; bus.cpu_we = 8'h3C; bus.cpu_addr = 64'h8000_0100; bus.cpu_wdata = 64'h0123_4567_89AB_CDEF;
        #1;
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 8'h3C, 64'h8000_0100, 64'h0123_4567_89AB_CDEF}) begin
            errors++;
            $display("FAIL ram_write_passthru: en=%b we=%h addr=%h wdata=%h", ram_en, ram_we, ram_addr, ram_wdata);
        end
        tick();
        bus.cpu_en = 1'b0; bus.cpu_we = 8'h00;
        ram_rdata = JUNK;
    endtask

    task automatic test_timer();
        bus_write(8'hFF, A_MTIME, 64'h0);
        bus_write(8'hFF, A_CMP, 64'h5);
        // mtime is now 1; it reaches 5 after four more edges, ext_int one edge later
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ext_int !== 1'b0) begin
                errors++;
                $display("FAIL timer_early cycle %0d: ext_int=%b want 0", i, ext_int);
            end
        end
        tick();
        checks++;
        if (ext_int !== 1'b1) begin
            errors++;
            $display("FAIL timer_fire: ext_int=%b want 1", ext_int);
        end
    endtask

    task automatic test_mtime_write();
        bus_write(8'hFF, A_MTIME, 64'h100);
        bus_write(8'h0F, A_MTIME, 64'hFFFF_FFFF_0000_0003);
        bus_read("mtime_partial", A_MTIME, 64'h3, 1'b0, JUNK);
        bus_read("mtime_next", A_MTIME, 64'h4, 1'b0, JUNK);
    endtask

    task automatic test_uart();
        int budget;
        logic [7:0] h;
        uart_tx_ready = 1'b0;
        exp_ovf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (uart_q.size() < 4) uart_q.push_back(8'hA0 + 8'(i));
            else                   exp_ovf = 1'b1;
            bus_write(8'h01, A_TX, {56'h0, 8'hA0 + 8'(i)});
        end
        bus_read("uart_status_full", A_STAT,
                 {61'h0, exp_ovf, uart_q.size() == 0, uart_q.size() == 4}, 1'b0, JUNK);
        uart_tx_ready = 1'b1;
        budget = 0;
        while (uart_q.size() > 0 && budget < 20) begin
            h = uart_q.pop_front();
            checks++;
            if (uart_tx_valid !== 1'b1 || uart_tx_data !== h) begin
                errors++;
                $display("FAIL uart_drain: valid=%b data=%h want valid=1 data=%h", uart_tx_valid, uart_tx_data, h);
            end
            tick();
            budget++;
        end
        uart_tx_ready = 1'b0;
        checks++;
        if (uart_tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL uart_empty_valid: valid=%b want 0", uart_tx_valid);
        end
        bus_read("uart_status_empty", A_STAT, 64'h6, 1'b0, JUNK);
        bus_write(8'h01, A_STAT, 64'h4);
        bus_read("uart_ovf_clear", A_STAT, 64'h2, 1'b0, JUNK);
        bus_read("uart_tx_reads0", A_TX, 64'h0, 1'b0, JUNK);
    endtask

    task automatic test_led_unmapped();
        bus_write(8'h03, A_LED, 64'hFFFF_FFFF_FFFF_BEEF);
        checks++;
        if (led !== 16'hBEEF) begin
            errors++;
            $display("FAIL led_write: led=%h want beef", led);
        end
        bus_read("led_read", A_LED, 64'hBEEF, 1'b0, JUNK);
        bus_write(8'h02, A_LED, 64'h0000_0000_0000_1234);
        checks++;
        if (led !== 16'h12EF) begin
            errors++;
            $display("FAIL led_byte_en: led=%h want 12ef", led);
        end
        bus_read("unmapped_read", 64'h2000_0000, EXP_UNM, 1'b0, JUNK);
        bus_read("reserved_read", 64'h1000_0028, EXP_UNM, 1'b0, JUNK);
        bus_read("status_buserr", A_STAT, 64'h2 | EXP_BE, 1'b0, JUNK);
        bus_write(8'h01, A_STAT, 64'h8);
        bus_read("status_buserr_clr", A_STAT, 64'h2, 1'b0, JUNK);
    endtask

    task automatic test_reset_midstream();
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_write(8'h01, A_TX, {56'h0, 8'h60 + 8'(i)});
        bus_write(8'hFF, A_MTIME, 64'h50);
        bus_write(8'h03, A_LED, 64'h00FF);
        // RAM read issued in the same cycle as reset must not steer the response
        rst = 1'b1;
        bus.cpu_en = 1'b1; bus.cpu_we = 8'h00; bus.cpu_addr = 64'h8000_0000;
        tick();
        bus.cpu_en = 1'b0;
        ram_rdata  = 64'hCAFE_F00D_CAFE_F00D;
        #1;
        checks++;
        if ({bus.cpu_rdata, ext_int, led, uart_tx_valid} !== {64'h0, 1'b0, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL midstream_reset: rdata=%h ext_int=%b led=%h valid=%b want all 0",
                     bus.cpu_rdata, ext_int, led, uart_tx_valid);
        end
        rst = 1'b0;
        uart_q.delete();
        bus_read("midreset_mtime", A_MTIME, 64'h0, 1'b0, JUNK);
        bus_read("midreset_status", A_STAT, 64'h2, 1'b0, JUNK);
    endtask

    initial begin
        test_reset();
        test_ram();
        test_timer();
        test_mtime_write();
        test_uart();
        test_led_unmapped();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/data_bus_bridge.md
Name: data_bus_bridge

Overview:
- Sits directly downstream of the core's data SRAM port (data_sram_*) and upstream of its ext_int input.
- Decodes each core data access to one of three targets: data RAM, an MMIO register block, or unmapped.
- The MMIO block holds a 64-bit machine timer with compare (drives ext_int), an LED register, and a small UART TX FIFO.
- Preserves the core's fixed 1-cycle SRAM read latency; never stalls the core.

Parameters:
- RAM_BASE, 64'h0000_0000_8000_0000, data RAM window base.
- RAM_SIZE_LOG2, 20, RAM window size = 2^RAM_SIZE_LOG2 bytes.
- MMIO_BASE, 64'h0000_0000_1000_0000, MMIO window base; window is 256 bytes.
- TIMER_DIV, 1, mtime increments once every TIMER_DIV clocks (≥1).
- UART_FIFO_DEPTH, 4, TX FIFO entries (power of 2).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- cpu_en  in  1  core data access valid (data_sram_en)
- cpu_we  in  8  per-byte write enables; 0 = read
- cpu_addr  in  64  byte address
- cpu_wdata  in  64  write data
- cpu_rdata  out  64  read data, one cycle after the request
- ram_en  out  1  RAM access
- ram_we  out  8  RAM byte enables
- ram_addr  out  64  RAM address (passed through)
- ram_wdata  out  64  RAM write data
- ram_rdata  in  64  RAM read data, 1-cycle latency
- ext_int  out  1  timer interrupt to core
- led  out  16  LED register
- uart_tx_valid  out  1  FIFO head valid
- uart_tx_data  out  8  FIFO head byte
- uart_tx_ready  in  1  consumer accepts head

Behaviour:
- Decode (combinational on request):
  - RAM hit: addr[63:RAM_SIZE_LOG2] matches the RAM window.
  - MMIO hit: addr[63:8] == MMIO_BASE[63:8]; offset = addr[7:3].
  - Otherwise: unmapped.
  - ram_en = cpu_en & RAM hit; ram_we/addr/wdata are pass-through.
- Read path: the request cycle registers sel_q (RAM/MMIO/unmapped) and mmio_rdata_q.
  - cpu_rdata = ram_rdata when sel_q is RAM, otherwise mmio_rdata_q.
  - Unmapped reads return 0.
- MMIO map (8-byte aligned offsets):
  - 0x00 MTIME: rw.
  - 0x08 MTIMECMP: rw.
  - 0x10 LED: rw; bits[15:0] only, others read 0.
  - 0x18 UART_TX: write with we[0] pushes wdata[7:0]; reads 0.
  - 0x20 UART_STATUS: ro bit0 full, bit1 empty, bit2 overflow sticky; a write with we[0] and wdata[2]=1 clears overflow.
  - All other offsets: read 0, writes ignored.
- Byte enables apply per byte to MTIME, MTIMECMP, LED.
- Timer:
  - Prescaler counts 0..TIMER_DIV-1; mtime += 1 on wrap.
  - A write to MTIME in the same cycle wins: written bytes take wdata, unwritten bytes keep the current value, no increment that cycle.
  - mtime wraps modulo 2^64.
- ext_int: registered (mtime ≥ mtimecmp), unsigned compare; updates one cycle after either operand changes.
- UART FIFO:
  - uart_tx_valid = !empty; uart_tx_data = head.
  - Pop when valid & ready.
  - Push on UART_TX write when not full; full is evaluated before the same-cycle pop.
  - A push while full is dropped and sets overflow.
  - Push and pop in the same cycle when neither full nor empty: count unchanged.
  - Pointers wrap modulo depth.
- Reset (synchronous): mtime=0, mtimecmp=all ones, prescaler=0, ext_int=0, led=0, FIFO empty, overflow=0, sel_q=unmapped, mmio_rdata_q=0, so cpu_rdata=0.
- Reset asserted mid-stream discards FIFO contents and any in-flight read select.

Optional Feature:
- Macro: DATA_BUS_BRIDGE_BUSERR_EN.
- Defined:
  - Any cpu_en access to unmapped space, or to a reserved MMIO offset, sets UART_STATUS bit3 (bus_err sticky).
  - Such reads return 64'hDEAD_BEEF_DEAD_BEEF.
  - Cleared by a status write with wdata[3]=1.
- Undefined: bit3 reads 0; those reads return 0.

Decomposition:
- Package data_bus_bridge_pkg:
  - MMIO offset constants (OFF_MTIME, OFF_MTIMECMP, OFF_LED, OFF_UART_TX, OFF_UART_STAT).
  - Status bit indices.
  - Target-select enum (SEL_RAM, SEL_MMIO, SEL_NONE).
  - BUSERR read pattern.
- One sub-module: uart_tx_fifo, a parameterised sync FIFO with push/pop/full/empty.

Test Plan:
- Read RAM 0x8000_0010 with ram_rdata=64'h1122_3344_5566_7788 next cycle -> ram_en=1 on the request cycle; cpu_rdata=64'h1122_3344_5566_7788 one cycle later.
- Write MTIMECMP=5 with MTIME=0, TIMER_DIV=1 -> ext_int rises on the cycle after mtime reaches 5.
- Write MTIME, we=8'h0F, wdata=64'hFFFF_FFFF_0000_0003, while mtime=0x100 -> mtime=0x0000_0000_0000_0003 next cycle (high bytes kept); increment suppressed that cycle.
- Push 5 bytes 0xA0..0xA4 with uart_tx_ready=0 -> 4 accepted; status reads full=1 and overflow=1; raise ready -> A0,A1,A2,A3 drain in order, then empty=1.
- Write LED 0xBEEF, then read 0x1000_0010 -> led=16'hBEEF; cpu_rdata=64'h0000_0000_0000_BEEF; read of address 0x2000_0000 returns 0 (or the DEAD_BEEF pattern plus bus_err when DATA_BUS_BRIDGE_BUSERR_EN is defined).
- Assert rst with 3 FIFO entries and mtime=0x50 -> next cycle all outputs at reset values; uart_tx_valid=0.
